// File: rtl/led_pkg.sv
// Shared definitions for the LED breathing controller: state encoding and defaults.
// Build option LED_ACTIVE_LOW_EN selects an active-low LED pin (off level = 1).
package led_pkg;

    localparam int PWM_BITS_DEF = 8;

    typedef logic [2:0] state_t;

    localparam state_t IDLE      = 3'd0;
    localparam state_t RAMP_UP   = 3'd1;
    localparam state_t HOLD_HIGH = 3'd2;
    localparam state_t RAMP_DOWN = 3'd3;
    localparam state_t HOLD_LOW  = 3'd4;

`ifdef LED_ACTIVE_LOW_EN
    localparam logic LED_OFF = 1'b1;
`else
    localparam logic LED_OFF = 1'b0;
`endif

endpackage

// File: rtl/led_breathe_pwm_gen.sv
// Free-running PWM counter with a registered compare output driving the LED pin.
// The pin polarity comes from led_pkg::LED_OFF (LED_ACTIVE_LOW_EN build option).
module pwm_gen
    import led_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] duty,
    output logic                led
);

    logic [PWM_BITS-1:0] pwm_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // XOR with the off level maps "on" to the correct pin polarity.
    always_ff @(posedge clock) begin
        if (reset) begin
            led <= LED_OFF;
        end else begin
            led <= (pwm_cnt < duty) ^ LED_OFF;
        end
    end

endmodule

// File: rtl/led_breathe.sv
// LED breathing controller: tick-paced ramp up / hold / ramp down / hold of a PWM duty.
// Build option LED_ACTIVE_LOW_EN inverts the LED pin (handled in led_pkg / pwm_gen).
//
//  state     | meaning
//  ----------+---------------------------------------------------
//  IDLE      | stopped, duty 0; first tick starts the ramp
//  RAMP_UP   | duty rises by STEP per tick, saturating at MAX
//  HOLD_HIGH | duty at MAX for HOLD_TICKS ticks
//  RAMP_DOWN | duty falls by STEP per tick, saturating at 0
//  HOLD_LOW  | duty at 0 for HOLD_TICKS ticks
module led_breathe
    import led_pkg::*;
#(
    parameter int PWM_BITS   = PWM_BITS_DEF,
    parameter int STEP       = 1,
    parameter int HOLD_TICKS = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                tick,
    input  logic                enable,
    output logic                led,
    output logic [PWM_BITS-1:0] duty,
    output logic [2:0]          state
);

    localparam int HW        = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam int HOLD_LAST = (HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0;

    localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
    localparam logic [PWM_BITS-1:0] STEP_W    = PWM_BITS'(STEP);
    localparam logic [HW-1:0]       HOLD_LAST_W = HW'(HOLD_LAST);

    logic [HW-1:0]       hold_cnt;
    logic [PWM_BITS:0]   duty_sum;
    logic [PWM_BITS-1:0] duty_up;
    logic [PWM_BITS-1:0] duty_dn;

    // Saturating step arithmetic: no wrap at either end of the range.
    always_comb begin
        duty_sum = {1'b0, duty} + {1'b0, STEP_W};
        duty_up  = (duty_sum > {1'b0, DUTY_MAX}) ? DUTY_MAX : duty_sum[PWM_BITS-1:0];
        duty_dn  = (duty < STEP_W) ? '0 : duty - STEP_W;
    end

    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            state    <= IDLE;
            duty     <= '0;
            hold_cnt <= '0;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    state <= RAMP_UP;
                end
                RAMP_UP: begin
                    duty <= duty_up;
                    if (duty_up == DUTY_MAX) begin
                        state    <= (HOLD_TICKS == 0) ? RAMP_DOWN : HOLD_HIGH;
                        hold_cnt <= '0;
                    end
                end
                HOLD_HIGH: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (hold_cnt == HOLD_LAST_W) begin
                        state <= RAMP_DOWN;
                    end
                end
                RAMP_DOWN: begin
                    duty <= duty_dn;
                    if (duty_dn == '0) begin
                        state    <= (HOLD_TICKS == 0) ? RAMP_UP : HOLD_LOW;
                        hold_cnt <= '0;
                    end
                end
                HOLD_LOW: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (hold_cnt == HOLD_LAST_W) begin
                        state <= RAMP_UP;
                    end
                end
                default: begin
                    state    <= IDLE;
                    duty     <= '0;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    pwm_gen #(
        .PWM_BITS(PWM_BITS)
    ) u_pwm_gen (
        .clock(clock),
        .reset(reset),
        .duty (duty),
        .led  (led)
    );

endmodule

// File: tb/tb_led_breathe.sv
// Directed bench for led_breathe with PWM_BITS=4, STEP=4, HOLD_TICKS=2.
module tb_led_breathe;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_UP   = 3'd1;
    localparam logic [2:0] S_HH   = 3'd2;
    localparam logic [2:0] S_DN   = 3'd3;
    localparam logic [2:0] S_HL   = 3'd4;

`ifdef LED_ACTIVE_LOW_EN
    localparam logic EXP_OFF = 1'b1;
`else
    localparam logic EXP_OFF = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       tick;
    logic       enable;
    logic       led;
    logic [3:0] duty;
    logic [2:0] state;

    int checks   = 0;
    int failures = 0;

    led_breathe #(
        .PWM_BITS  (4),
        .STEP      (4),
        .HOLD_TICKS(2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .tick  (tick),
        .enable(enable),
        .led   (led),
        .duty  (duty),
        .state (state)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic       en;
        logic       tk;
        logic [2:0] exp_state;
        logic [3:0] exp_duty;
        int         gap;
    } vec_t;

    vec_t vecs[28];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic t);
        reset  = r;
        enable = e;
        tick   = t;
        @(posedge clock);
        #1;
    endtask

    task automatic count_on(input int exp, input string name);
        int on_cnt;
        on_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            step(1'b0, enable, 1'b0);
            if (led != EXP_OFF) on_cnt++;
        end
        chk(name, on_cnt, exp);
    endtask

    initial begin
        vecs[0]  = '{0, 1, 0, S_IDLE, 4'd0,  0};
        vecs[1]  = '{0, 1, 1, S_UP,   4'd0,  19};
        vecs[2]  = '{0, 1, 1, S_UP,   4'd4,  19};
        vecs[3]  = '{0, 1, 1, S_UP,   4'd8,  19};
        vecs[4]  = '{0, 1, 1, S_UP,   4'd12, 19};
        vecs[5]  = '{0, 1, 1, S_HH,   4'd15, 19};
        vecs[6]  = '{0, 1, 1, S_HH,   4'd15, 0};
        vecs[7]  = '{0, 1, 1, S_DN,   4'd15, 0};
        vecs[8]  = '{0, 1, 1, S_DN,   4'd11, 0};
        vecs[9]  = '{0, 1, 1, S_DN,   4'd7,  0};
        vecs[10] = '{0, 1, 1, S_DN,   4'd3,  0};
        vecs[11] = '{0, 1, 1, S_HL,   4'd0,  0};
        vecs[12] = '{0, 1, 1, S_HL,   4'd0,  5};
        vecs[13] = '{0, 1, 1, S_UP,   4'd0,  0};
        vecs[14] = '{0, 1, 1, S_UP,   4'd4,  0};
        vecs[15] = '{0, 1, 1, S_UP,   4'd8,  0};
        vecs[16] = '{0, 0, 1, S_IDLE, 4'd0,  0};
        vecs[17] = '{0, 1, 1, S_UP,   4'd0,  0};
        vecs[18] = '{0, 1, 0, S_UP,   4'd0,  0};
        vecs[19] = '{0, 1, 1, S_UP,   4'd4,  0};
        vecs[20] = '{0, 1, 1, S_UP,   4'd8,  0};
        vecs[21] = '{0, 1, 1, S_UP,   4'd12, 0};
        vecs[22] = '{0, 1, 1, S_HH,   4'd15, 0};
        vecs[23] = '{0, 1, 1, S_HH,   4'd15, 0};
        vecs[24] = '{1, 1, 1, S_IDLE, 4'd0,  0};
        vecs[25] = '{0, 1, 1, S_UP,   4'd0,  0};
        vecs[26] = '{0, 1, 1, S_UP,   4'd4,  0};
        vecs[27] = '{0, 0, 0, S_IDLE, 4'd0,  0};

        reset  = 1'b1;
        enable = 1'b1;
        tick   = 1'b1;
        #2;

        // Reset held 3 clocks with tick and enable active
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1);
            chk("reset_led",   int'(led),   int'(EXP_OFF));
            chk("reset_duty",  int'(duty),  0);
            chk("reset_state", int'(state), int'(S_IDLE));
        end

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].tk);
            chk($sformatf("vec%0d_state", i), int'(state), int'(vecs[i].exp_state));
            chk($sformatf("vec%0d_duty", i),  int'(duty),  int'(vecs[i].exp_duty));
            if (vecs[i].gap > 0) begin
                for (int g = 0; g < vecs[i].gap; g++) step(1'b0, vecs[i].en, 1'b0);
                chk($sformatf("vec%0d_gap_state", i), int'(state), int'(vecs[i].exp_state));
                chk($sformatf("vec%0d_gap_duty", i),  int'(duty),  int'(vecs[i].exp_duty));
            end
        end

        // Duty 0 while disabled: LED never on
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        count_on(0, "pwm_duty0");

        // Ramp to 8 and hold there
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk("seq_duty8", int'(duty), 8);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        count_on(8, "pwm_duty8");

        // Drop enable at duty 8: IDLE next clock, LED off within 2 clocks
        step(1'b0, 1'b0, 1'b0);
        chk("drop_state", int'(state), int'(S_IDLE));
        chk("drop_duty",  int'(duty),  0);
        step(1'b0, 1'b0, 1'b0);
        chk("drop_led", int'(led), int'(EXP_OFF));
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (led != EXP_OFF) chk("drop_led_stays_off", int'(led), int'(EXP_OFF));
        end

        // Ramp to 15, held in HOLD_HIGH by withholding ticks
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1);
        chk("seq_hh_state", int'(state), int'(S_HH));
        chk("seq_hh_duty",  int'(duty),  15);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        count_on(15, "pwm_duty15");

        // Reset pulse mid-hold, then restart from IDLE
        step(1'b1, 1'b1, 1'b0);
        chk("rst_hold_state", int'(state), int'(S_IDLE));
        chk("rst_hold_duty",  int'(duty),  0);
        step(1'b0, 1'b1, 1'b1);
        chk("restart_state", int'(state), int'(S_UP));
        chk("restart_duty",  int'(duty),  0);
        step(1'b0, 1'b1, 1'b1);
        chk("restart_duty2", int'(duty),  4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_breathe.md
LED_BREATHE -- requirements
Module: led_breathe

Interface
REQ-001 SHALL provide parameter PWM_BITS, default 8, meaning width of duty and PWM counter; MAX = 2^PWM_BITS-1.
REQ-002 SHALL provide parameter STEP, default 1, meaning duty increment/decrement per accepted tick (1..MAX).
REQ-003 SHALL provide parameter HOLD_TICKS, default 16, meaning accepted ticks spent at each extreme (0 = no hold).
REQ-004 SHALL provide port clock  input  1  single clock; all logic on posedge clock.
REQ-005 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL provide port tick  input  1  one-cycle step strobe from the upstream 0.5 s/period divider.
REQ-007 SHALL provide port enable  input  1  run request; low forces IDLE.
REQ-008 SHALL provide port led  output  1  registered PWM drive to LED pin.
REQ-009 SHALL provide port duty  output  PWM_BITS  current brightness level.
REQ-010 SHALL provide port state  output  3  current FSM state encoding.

Function
REQ-011 SHALL run free-running pwm_cnt (PWM_BITS) incrementing every clock, wrapping MAX -> 0.
REQ-012 SHALL register led = (pwm_cnt < duty), one clock latency; duty 0 -> never on; duty MAX -> on MAX of every MAX+1 clocks.
REQ-013 SHALL implement states IDLE, RAMP_UP, HOLD_HIGH, RAMP_DOWN, HOLD_LOW; FSM advances only on clocks with tick=1 and enable=1.
REQ-014 IDLE: on tick -> RAMP_UP, duty unchanged (0).
REQ-015 RAMP_UP: on tick duty <= min(duty+STEP, MAX), no overflow wrap; when new duty = MAX -> HOLD_HIGH (or RAMP_DOWN if HOLD_TICKS=0), hold_cnt <= 0.
REQ-016 HOLD_HIGH: on tick hold_cnt++; on the tick where hold_cnt = HOLD_TICKS-1 -> RAMP_DOWN.
REQ-017 RAMP_DOWN: on tick duty <= max(duty-STEP, 0), no underflow wrap; when new duty = 0 -> HOLD_LOW (or RAMP_UP if HOLD_TICKS=0), hold_cnt <= 0.
REQ-018 HOLD_LOW: mirror of HOLD_HIGH, exit -> RAMP_UP.
REQ-019 enable=0 SHALL, on next clock, force state IDLE, duty 0, hold_cnt 0, regardless of tick; pwm_cnt keeps running.
REQ-020 tick asserted for consecutive clocks SHALL be treated as one step per clock.

Reset
REQ-021 reset SHALL take priority over enable and tick.
REQ-022 On reset: state IDLE, duty 0, hold_cnt 0, pwm_cnt 0, led at off level (REQ-024).
REQ-023 Reset mid-ramp or mid-hold SHALL abandon the cycle; the block restarts from IDLE after release.

Configuration
REQ-024 Macro LED_ACTIVE_LOW_EN defined: led output SHALL be inverted (off = 1, including reset); undefined: led active-high (off = 0).

Structure
REQ-025 Package led_pkg SHALL hold the state typedef/encoding and default PWM_BITS constant.
REQ-026 Sub-module pwm_gen (pwm_cnt + comparator + output register) SHALL be instantiated once.

Verification (PWM_BITS=4, STEP=4, HOLD_TICKS=2)
REQ-027 reset=1 for 3 clocks with tick=1, enable=1 -> led off, duty 0, state IDLE throughout.
REQ-028 enable=1, tick every 20 clocks -> duty 0,4,8,12,15, 2 ticks HOLD_HIGH, then 11,7,3,0, 2 ticks HOLD_LOW, RAMP_UP.
REQ-029 duty held at 8 -> led on exactly 8 of each 16 clocks; duty 15 -> 15 of 16; duty 0 -> 0.
REQ-030 enable dropped at duty 8 -> next clock state IDLE, duty 0; led off within 2 clocks.
REQ-031 reset pulsed in HOLD_HIGH -> IDLE, duty 0; next tick with enable -> RAMP_UP, duty 0 (advances on following tick).
REQ-032 LED_ACTIVE_LOW_EN defined, duty 0 -> led constant 1; duty 8 -> led low 8 of 16 clocks.
